// File: rtl/gnn_frame_loader.sv
// gnn_frame_loader
//   Stream-side frame assembler for the 4-node 2-layer GNN compute top.
//   Collects 16 feature words followed by 24 weight words from a
//   valid/ready stream and presents them as stable parallel buses. It then
//   raises in_ready_o as a level and holds the frame until all eight
//   out-ready flags are set. After that it drops in_ready_o for GAP cycles,
//   so the next frame produces a fresh rising edge.
//   Optional feature macro: GNN_LOADER_TIMEOUT_EN. When it is defined, a
//   watchdog limits how long the loader waits in RUN.
module gnn_frame_loader #(
    parameter int DW      = 5,
    parameter int N_FEAT  = 16,
    parameter int N_WGT   = 24,
    parameter int GAP     = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    input  logic [DW-1:0]           s_data,
    input  logic                    s_last,
    output logic                    s_ready,
    input  logic [7:0]              out_ready_i,
    output logic [N_FEAT*DW-1:0]    feat_o,
    output logic [N_WGT*DW-1:0]     wgt_o,
    output logic                    in_ready_o,
    output logic                    frame_err_o,
    output logic                    timeout_o,
    output logic [7:0]              frame_cnt_o
);

    localparam int N_WORDS = N_FEAT + N_WGT;
    localparam logic [5:0] LAST_IDX = 6'(N_WORDS - 1);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_ARM,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t          state;
    logic [5:0]      word_cnt;
    logic [GW-1:0]   gap_cnt;

`ifdef GNN_LOADER_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    logic [7:0]      tmo_cnt;
    logic            tmo_flag;

    assign timeout_o = tmo_flag;
`else
    logic            unused_timeout;

    assign unused_timeout = ^TIMEOUT;
    assign timeout_o      = 1'b0;
`endif

    // Frame FSM: beat capture, arm/hold handshake with the compute top, inter-frame gap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_LOAD;
            word_cnt    <= '0;
            gap_cnt     <= '0;
            feat_o      <= '0;
            wgt_o       <= '0;
            s_ready     <= 1'b0;
            in_ready_o  <= 1'b0;
            frame_err_o <= 1'b0;
            frame_cnt_o <= '0;
`ifdef GNN_LOADER_TIMEOUT_EN
            tmo_cnt     <= '0;
            tmo_flag    <= 1'b0;
`endif
        end else begin
            frame_err_o <= 1'b0;
            case (state)
                ST_LOAD: begin
                    s_ready <= 1'b1;
                    if (s_valid && s_ready) begin
                        // Word index selects its bus slot. s_data is only looked at here.
                        for (int unsigned k = 0; k < N_FEAT; k++) begin
                            if (word_cnt == 6'(k)) begin
                                feat_o[k*DW +: DW] <= s_data;
                            end
                        end
                        for (int unsigned j = 0; j < N_WGT; j++) begin
                            if (word_cnt == 6'(N_FEAT + j)) begin
                                wgt_o[j*DW +: DW] <= s_data;
                            end
                        end
                        if (word_cnt == LAST_IDX) begin
                            word_cnt <= '0;
                            if (s_last) begin
                                state      <= ST_ARM;
                                s_ready    <= 1'b0;
                                in_ready_o <= 1'b1;
                            end else begin
                                frame_err_o <= 1'b1;
                            end
                        end else if (s_last) begin
                            word_cnt    <= '0;
                            frame_err_o <= 1'b1;
                        end else begin
                            word_cnt <= word_cnt + 6'd1;
                        end
                    end
                end

                ST_ARM: begin
                    // One cycle in which done is ignored, so the level is held for at least two cycles
                    state <= ST_RUN;
`ifdef GNN_LOADER_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                end

                ST_RUN: begin
                    if (&out_ready_i) begin
                        state       <= ST_DRAIN;
                        in_ready_o  <= 1'b0;
                        gap_cnt     <= '0;
                        frame_cnt_o <= frame_cnt_o + 8'd1;
                    end
`ifdef GNN_LOADER_TIMEOUT_EN
                    else if (tmo_cnt == TMO_LAST) begin
                        state      <= ST_DRAIN;
                        in_ready_o <= 1'b0;
                        gap_cnt    <= '0;
                        tmo_flag   <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
`endif
                end

                ST_DRAIN: begin
                    if (gap_cnt == GAP_LAST) begin
                        state   <= ST_LOAD;
                        s_ready <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gnn_frame_loader.sv
// tb_gnn_frame_loader
//   Randomized stimulus against a cycle-timing reference model of the loader.
//   The model is expressed as word lists and phase counters. The bench also
//   makes literal checks of latency, hold length, gap length and error pulses.
module tb_gnn_frame_loader;

    localparam int DW      = 5;
    localparam int N_FEAT  = 16;
    localparam int N_WGT   = 24;
    localparam int N_WORDS = N_FEAT + N_WGT;
    localparam int GAP     = 2;
    localparam int TIMEOUT = 8;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic                  s_valid = 1'b0;
    logic [DW-1:0]         s_data = '0;
    logic                  s_last = 1'b0;
    logic                  s_ready;
    logic [7:0]            out_ready_i = '0;
    logic [N_FEAT*DW-1:0]  feat_o;
    logic [N_WGT*DW-1:0]   wgt_o;
    logic                  in_ready_o;
    logic                  frame_err_o;
    logic                  timeout_o;
    logic [7:0]            frame_cnt_o;

    int unsigned errors = 0;
    int unsigned checks = 0;
    bit          finished = 1'b0;
    int unsigned rdy_seen;
    logic [DW-1:0] frame_words [N_WORDS];

    gnn_frame_loader #(
        .DW(DW),
        .N_FEAT(N_FEAT),
        .N_WGT(N_WGT),
        .GAP(GAP),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .s_valid(s_valid),
        .s_data(s_data),
        .s_last(s_last),
        .s_ready(s_ready),
        .out_ready_i(out_ready_i),
        .feat_o(feat_o),
        .wgt_o(wgt_o),
        .in_ready_o(in_ready_o),
        .frame_err_o(frame_err_o),
        .timeout_o(timeout_o),
        .frame_cnt_o(frame_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic finish_run();
        if (!finished) begin
            finished = 1'b1;
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
            if (errors > 100) finish_run();
        end
    endtask

    // ---------------- reference model ----------------
    // Words received so far, position within the frame, and how long the
    // frame has been presented or how much of the gap is still left.
    logic [DW-1:0] m_word [N_WORDS];
    int unsigned   m_idx, m_hi, m_gap;
    logic          m_s_ready, m_in_ready, m_err, m_tmo;
    logic [7:0]    m_fcnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_WORDS; i++) m_word[i] <= '0;
            m_idx <= 0; m_hi <= 0; m_gap <= 0;
            m_s_ready <= 1'b0; m_in_ready <= 1'b0; m_err <= 1'b0;
            m_tmo <= 1'b0; m_fcnt <= '0;
        end else begin
            m_err <= 1'b0;
            if (m_in_ready) begin
                if (m_hi >= 2 && out_ready_i == 8'hFF) begin
                    m_in_ready <= 1'b0;
                    m_gap      <= GAP;
                    m_fcnt     <= m_fcnt + 8'd1;
                end
`ifdef GNN_LOADER_TIMEOUT_EN
                else if (m_hi - 1 == TIMEOUT) begin
                    m_in_ready <= 1'b0;
                    m_gap      <= GAP;
                    m_tmo      <= 1'b1;
                end
`endif
                else begin
                    m_hi <= m_hi + 1;
                end
            end else if (m_gap != 0) begin
                m_gap <= m_gap - 1;
                if (m_gap == 1) m_s_ready <= 1'b1;
            end else begin
                m_s_ready <= 1'b1;
                if (s_valid && m_s_ready) begin
                    m_word[m_idx] <= s_data;
                    if (s_last && m_idx == N_WORDS - 1) begin
                        m_in_ready <= 1'b1;
                        m_s_ready  <= 1'b0;
                        m_hi       <= 1;
                        m_idx      <= 0;
                    end else if (s_last || m_idx == N_WORDS - 1) begin
                        m_err <= 1'b1;
                        m_idx <= 0;
                    end else begin
                        m_idx <= m_idx + 1;
                    end
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin : compare
        logic [N_FEAT*DW-1:0] ef;
        logic [N_WGT*DW-1:0]  ew;
        for (int i = 0; i < N_FEAT; i++) ef[i*DW +: DW] = m_word[i];
        for (int j = 0; j < N_WGT; j++) ew[j*DW +: DW] = m_word[N_FEAT + j];
        chk("cyc_s_ready", s_ready, m_s_ready);
        chk("cyc_in_ready", in_ready_o, m_in_ready);
        chk("cyc_frame_err", frame_err_o, m_err);
        chk("cyc_timeout", timeout_o, m_tmo);
        chk("cyc_frame_cnt", frame_cnt_o, m_fcnt);
        chk("cyc_feat", feat_o, ef);
        chk("cyc_wgt", wgt_o, ew);
    end

    initial begin
        #5000000;
        chk("watchdog_expired", 1'b1, 1'b0);
        finish_run();
    end

    // ---------------- stimulus helpers ----------------
    task automatic fill_pattern();
        for (int i = 0; i < N_WORDS; i++) frame_words[i] = 5'((i % 16) - 8);
    endtask

    task automatic fill_random();
        for (int i = 0; i < N_WORDS; i++) frame_words[i] = 5'($urandom_range(31));
    endtask

    task automatic send_word(input logic [DW-1:0] d, input logic last, input int unsigned idle_pct);
        int unsigned guard;
        bit sent;
        guard = 0;
        sent  = 1'b0;
        while (!sent) begin
            @(negedge clk);
            if (s_ready) rdy_seen++;
            if ($urandom_range(99) < idle_pct) begin
                s_valid = 1'b0;
                s_data  = 'x;
                s_last  = 1'($urandom_range(1));
            end else begin
                s_valid = 1'b1;
                s_data  = d;
                s_last  = last;
                sent    = s_ready;
            end
            guard++;
            if (!sent && guard > 500) begin
                chk("send_word_stall", 1'b0, 1'b1);
                sent = 1'b1;
            end
        end
    endtask

    task automatic send_frame(input int n, input int last_pos, input int unsigned idle_pct);
        for (int i = 0; i < n; i++) send_word(frame_words[i], (i == last_pos), idle_pct);
    endtask

    task automatic park();
        @(negedge clk);
        s_valid = 1'b0;
        s_data  = 'x;
        s_last  = 1'b0;
    endtask

    task automatic wait_load();
        int unsigned guard;
        guard = 0;
        while (!s_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("wait_load_ready", s_ready, 1'b1);
    endtask

    task automatic run_release(input int unsigned hold);
        for (int unsigned k = 0; k < hold; k++) begin
            out_ready_i = 8'($urandom_range(254));
            @(negedge clk);
        end
        out_ready_i = 8'hFF;
        wait_load();
    endtask

    task automatic check_buses(input string tag);
        logic [N_FEAT*DW-1:0] ef;
        logic [N_WGT*DW-1:0]  ew;
        for (int i = 0; i < N_FEAT; i++) ef[i*DW +: DW] = frame_words[i];
        for (int j = 0; j < N_WGT; j++) ew[j*DW +: DW] = frame_words[N_FEAT + j];
        chk({tag, "_feat"}, feat_o, ef);
        chk({tag, "_wgt"}, wgt_o, ew);
    endtask

    // ---------------- test sequence ----------------
    initial begin : main
        int unsigned hi;
        int unsigned lo;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready_o, 1'b0);
        chk("rst_frame_cnt", frame_cnt_o, 8'd0);
        chk("rst_feat", feat_o, '0);
        rst_n = 1'b1;
        #1 chk("rst_s_ready_low", s_ready, 1'b0);
        @(negedge clk);
        chk("s_ready_after_rst", s_ready, 1'b1);

        // Back-to-back reference frame, done already high at arm time
        out_ready_i = 8'hFF;
        fill_pattern();
        rdy_seen = 0;
        send_frame(N_WORDS, N_WORDS - 1, 0);
        park();
        chk("arm_latency", in_ready_o, 1'b1);
        chk("s_ready_high_cycles", rdy_seen, 40);
        chk("s_ready_low_on_arm", s_ready, 1'b0);
        chk("feat0_lit", feat_o[4:0], 5'b11000);
        chk("wgt0_lit", wgt_o[4:0], 5'b11000);
        chk("feat15_lit", feat_o[79:75], 5'd7);
        check_buses("b2b");
        hi = 0;
        while (in_ready_o && hi < 50) begin
            hi++;
            @(negedge clk);
        end
        chk("in_ready_high_cycles", hi, 2);
        lo = 0;
        while (!s_ready && lo < 50) begin
            lo++;
            @(negedge clk);
        end
        chk("gap_cycles", lo, GAP);
        chk("frame_cnt_one", frame_cnt_o, 8'd1);

        // Early s_last on word 10
        fill_random();
        send_frame(11, 10, 0);
        park();
        chk("early_last_err", frame_err_o, 1'b1);
        chk("early_last_no_arm", in_ready_o, 1'b0);
        @(negedge clk);
        chk("early_last_err_pulse", frame_err_o, 1'b0);
        fill_random();
        send_frame(N_WORDS, N_WORDS - 1, 0);
        park();
        chk("after_err_arm", in_ready_o, 1'b1);
        check_buses("after_err");
        run_release(3);

        // Missing s_last on word 39
        fill_random();
        send_frame(N_WORDS, -1, 0);
        park();
        chk("missing_last_err", frame_err_o, 1'b1);
        chk("missing_last_no_arm", in_ready_o, 1'b0);

        // Reference pattern again with idle gaps and X on idle data
        fill_pattern();
        send_frame(N_WORDS, N_WORDS - 1, 50);
        park();
        chk("gappy_arm", in_ready_o, 1'b1);
        chk("gappy_feat0_lit", feat_o[4:0], 5'b11000);
        check_buses("gappy");
        run_release($urandom_range(5));

        for (int f = 0; f < 6; f++) begin
            fill_random();
            send_frame(N_WORDS, N_WORDS - 1, 30);
            park();
            check_buses("rand");
            run_release($urandom_range(5));
        end
        chk("frame_cnt_nine", frame_cnt_o, 8'd9);

        // Reset while waiting in RUN
        out_ready_i = 8'h00;
        fill_random();
        send_frame(N_WORDS, N_WORDS - 1, 0);
        park();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrun_rst_in_ready", in_ready_o, 1'b0);
        chk("midrun_rst_feat", feat_o, '0);
        chk("midrun_rst_wgt", wgt_o, '0);
        chk("midrun_rst_cnt", frame_cnt_o, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrun_rst_ready", s_ready, 1'b1);
        out_ready_i = 8'hFF;
        fill_random();
        send_frame(N_WORDS, N_WORDS - 1, 0);
        park();
        chk("recover_arm", in_ready_o, 1'b1);
        check_buses("recover");
        run_release(0);

`ifdef GNN_LOADER_TIMEOUT_EN
        out_ready_i = 8'h7F;
        fill_random();
        send_frame(N_WORDS, N_WORDS - 1, 0);
        park();
        hi = 0;
        while (in_ready_o && hi < 50) begin
            hi++;
            @(negedge clk);
        end
        chk("timeout_high_cycles", hi, TIMEOUT + 1);
        chk("timeout_flag", timeout_o, 1'b1);
        chk("timeout_cnt_kept", frame_cnt_o, 8'd1);
        wait_load();
        out_ready_i = 8'hFF;
`endif

        // Frame counter wrap: from 1, 254 frames reach 255, one more wraps to 0
        for (int f = 0; f < 255; f++) begin
            fill_random();
            send_frame(N_WORDS, N_WORDS - 1, 10);
            park();
            run_release(0);
            if (f == 253) chk("frame_cnt_255", frame_cnt_o, 8'd255);
        end
        chk("frame_cnt_wrap", frame_cnt_o, 8'd0);

        repeat (3) @(negedge clk);
        finish_run();
    end

endmodule
